// File: rtl/pipe_bus_sequencer.sv
// Memory-bus sequencer for the pipelined CPU: arbitrates MEMDATA between data, fetch and DMA,
// and drives the stage stall and branch-bubble controls.
module pipe_bus_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned DMA_WAIT_MAX = 8
) (
    input  logic       ClockIn,
    input  logic       ResetIn,
    input  logic       FetchReq,
    input  logic       DataReq,
    input  logic       DmaReq,
    input  logic       MemReady,
    input  logic       BranchTaken,
    output logic [1:0] GrantOut,
    output logic       FetchStallOut,
    output logic       DataStallOut,
    output logic       BubbleOut,
    output logic       BusyOut
);

    localparam logic [7:0] DMA_WAIT_LIM = 8'(DMA_WAIT_MAX);
    localparam logic [3:0] FLUSH_LOAD   = 4'(FLUSH_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'b00,
        OWN_FETCH = 2'b01,
        OWN_DATA  = 2'b10,
        OWN_DMA   = 2'b11
    } owner_t;

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     winner;
    logic [7:0] dma_wait_q, dma_wait_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic       arb_en;
    logic       fetch_elig;
    logic       data_elig;
    logic       dma_elig;
    logic       dma_urgent;

    // Request masking: the owner completing this cycle may not immediately win again.
    always_comb begin
        fetch_elig = FetchReq;
        data_elig  = DataReq;
        dma_elig   = DmaReq;
        arb_en     = 1'b0;
        if (state_q == ST_IDLE) begin
            arb_en = 1'b1;
        end else if (MemReady) begin
            arb_en = 1'b1;
            unique case (owner_q)
                OWN_FETCH: fetch_elig = 1'b0;
                OWN_DATA:  data_elig  = 1'b0;
                OWN_DMA:   dma_elig   = 1'b0;
                default:   ;
            endcase
        end
    end

    assign dma_urgent = (dma_wait_q >= DMA_WAIT_LIM);

    always_comb begin
        winner = OWN_NONE;
        if (data_elig) begin
            winner = OWN_DATA;
        end else if (dma_elig && dma_urgent) begin
            winner = OWN_DMA;
        end else if (fetch_elig) begin
            winner = OWN_FETCH;
        end else if (dma_elig) begin
            winner = OWN_DMA;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (arb_en) begin
            if (winner != OWN_NONE) begin
                state_d = ST_OWN;
                owner_d = winner;
            end else begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        end
    end

    always_ff @(posedge ClockIn or negedge ResetIn) begin
        if (!ResetIn) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign GrantOut = (state_q == ST_OWN) ? owner_q : OWN_NONE;
    assign BusyOut  = (GrantOut != OWN_NONE);

    assign DataStallOut  = DataReq & ~((GrantOut == OWN_DATA) & MemReady);
    assign FetchStallOut = (FetchReq & ~((GrantOut == OWN_FETCH) & MemReady)) | DataStallOut;

    // DMA starvation tracking; a DMA grant or a dropped request starts the count over.
    always_comb begin
        dma_wait_d = dma_wait_q;
        if (!DmaReq || (arb_en && winner == OWN_DMA)) begin
            dma_wait_d = '0;
        end else if (GrantOut != OWN_DMA && dma_wait_q < DMA_WAIT_LIM) begin
            dma_wait_d = dma_wait_q + 8'd1;
        end
    end

    // A bubble is only consumed when stage 1 actually advances.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (BranchTaken) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q != '0 && !FetchStallOut) begin
            flush_cnt_d = flush_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge ClockIn or negedge ResetIn) begin
        if (!ResetIn) begin
            dma_wait_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            dma_wait_q  <= dma_wait_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign BubbleOut = (flush_cnt_q != '0);

endmodule

// File: tb/tb_pipe_bus_sequencer.sv
// Scoreboard bench for pipe_bus_sequencer: directed scenarios followed by random traffic,
// each cycle checked against a cycle-level reference model.
module tb_pipe_bus_sequencer;

    localparam int FLUSH = 2;
    localparam int WAITMAX = 8;

    logic       clk;
    logic       rst_n;
    logic       fetch_req, data_req, dma_req, mem_ready, branch_taken;
    logic [1:0] grant;
    logic       fetch_stall, data_stall, bubble, busy;

    typedef struct packed {
        logic [1:0] grant;
        logic       fstall;
        logic       dstall;
        logic       bubble;
        logic       busy;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: current bus owner (0 none, 1 fetch, 2 data, 3 DMA),
    // denied-DMA streak and outstanding bubbles.
    int m_owner = 0;
    int m_wait  = 0;
    int m_flush = 0;

    pipe_bus_sequencer #(
        .FLUSH_CYCLES(FLUSH),
        .DMA_WAIT_MAX(WAITMAX)
    ) dut (
        .ClockIn      (clk),
        .ResetIn      (rst_n),
        .FetchReq     (fetch_req),
        .DataReq      (data_req),
        .DmaReq       (dma_req),
        .MemReady     (mem_ready),
        .BranchTaken  (branch_taken),
        .GrantOut     (grant),
        .FetchStallOut(fetch_stall),
        .DataStallOut (data_stall),
        .BubbleOut    (bubble),
        .BusyOut      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle(input bit rst_v, input bit f, input bit d, input bit m,
                         input bit mr, input bit bt);
        obs_t e;
        int   nxt;
        bit   arb, ef, ed, em;
        @(posedge clk);
        #2;
        rst_n        = rst_v;
        fetch_req    = f;
        data_req     = d;
        dma_req      = m;
        mem_ready    = mr;
        branch_taken = bt;
        if (!rst_v) begin
            m_owner = 0;
            m_wait  = 0;
            m_flush = 0;
        end
        e.grant  = 2'(m_owner);
        e.busy   = (m_owner != 0);
        e.bubble = (m_flush != 0);
        e.dstall = d && !(m_owner == 2 && mr);
        e.fstall = (f && !(m_owner == 1 && mr)) || e.dstall;
        exp_q.push_back(e);
        if (rst_v) begin
            arb = (m_owner == 0) || mr;
            ef = f; ed = d; em = m;
            if (m_owner != 0 && mr) begin
                if (m_owner == 1) ef = 0;
                if (m_owner == 2) ed = 0;
                if (m_owner == 3) em = 0;
            end
            nxt = m_owner;
            if (arb) begin
                if (ed) nxt = 2;
                else if (em && m_wait >= WAITMAX) nxt = 3;
                else if (ef) nxt = 1;
                else if (em) nxt = 3;
                else nxt = 0;
            end
            if (!m || (arb && nxt == 3)) m_wait = 0;
            else if (m_owner != 3 && m_wait < WAITMAX) m_wait = m_wait + 1;
            if (bt) m_flush = FLUSH;
            else if (m_flush > 0 && !e.fstall) m_flush = m_flush - 1;
            m_owner = nxt;
        end
    endtask

    // Monitor: outputs are compared mid-cycle, well away from the rising edge.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{grant: grant, fstall: fetch_stall, dstall: data_stall,
                      bubble: bubble, busy: busy};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t: got grant=%b fstall=%b dstall=%b bubble=%b busy=%b, expected grant=%b fstall=%b dstall=%b bubble=%b busy=%b",
                             $time, a.grant, a.fstall, a.dstall, a.bubble, a.busy,
                             e.grant, e.fstall, e.dstall, e.bubble, e.busy);
                end
            end
        end
    end

    initial begin
        rst_n = 0; fetch_req = 0; data_req = 0; dma_req = 0; mem_ready = 0; branch_taken = 0;
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        // Fetch only, MemReady every second cycle.
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, (i % 2) == 1, 0);
        repeat (3) cycle(1, 0, 0, 0, 0, 0);
        // Fetch and data together from idle.
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, (i % 3) == 2, 0);
        repeat (3) cycle(1, 0, 0, 0, 1, 0);
        // Fetch and DMA held with MemReady every cycle, then data mixed in to age DMA.
        for (int i = 0; i < 24; i++) cycle(1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 30; i++) cycle(1, 1, 1, 1, 1, 0);
        repeat (3) cycle(1, 0, 0, 0, 1, 0);
        // Branch pulses without stalls, second pulse in the first bubble cycle.
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        // Branch while a data access is stalled.
        cycle(1, 0, 1, 0, 0, 1);
        repeat (3) cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 1, 0);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        // Reset mid data transfer, with a bubble outstanding.
        cycle(1, 0, 1, 0, 0, 1);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0);
        repeat (4) cycle(1, 1, 1, 0, 1, 0);
        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) == 0));
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
